// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT pipeline: the FIFO entry layout
// and the pair-scheduler state encoding.
package ntt_pkg;

  localparam int N    = 256;
  localparam int LOGN = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_WB = 2'd2,
    S_DONE    = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic        is_intt;
    logic [7:0]  stage;
    logic [7:0]  counter;
    logic [31:0] index1;
    logic [31:0] index2;
    logic [31:0] index3;
    logic [31:0] index4;
    logic [31:0] tf_index1;
    logic [31:0] tf_index2;
  } ntt_pipeline_data_t;

endpackage

// File: rtl/ntt_index_decode.sv
// Maps (stage, butterfly number, direction) to the two coefficient addresses
// and the twiddle-table index of one radix-2 butterfly.
module ntt_index_decode #(
  parameter int N    = ntt_pkg::N,
  parameter int LOGN = ntt_pkg::LOGN
) (
  input  logic [LOGN-1:0] s,
  input  logic [LOGN-2:0] bfly,
  input  logic            is_intt,
  output logic [LOGN-1:0] idx_lo,
  output logic [LOGN-1:0] idx_hi,
  output logic [LOGN-1:0] tf
);

  localparam logic [LOGN-1:0] LAST_S = LOGN'(LOGN - 1);
  localparam logic [LOGN-1:0] ONE    = LOGN'(1);
  localparam logic [LOGN:0]   N_W    = (LOGN + 1)'(N);

  logic [LOGN-1:0] lg;
  logic [LOGN-1:0] bw;
  logic [LOGN-1:0] len;
  logic [LOGN-1:0] grp;
  logic [LOGN-1:0] ofs;

  // Group length is a power of two, so divide/modulo reduce to shift/mask.
  // Everything stays below N, so modulo-N arithmetic is exact.
  always_comb begin
    lg     = is_intt ? s : (LAST_S - s);
    bw     = LOGN'(bfly);
    len    = ONE << lg;
    grp    = bw >> lg;
    ofs    = bw & (len - ONE);
    idx_lo = ((grp << lg) << 1) + ofs;
    idx_hi = idx_lo + len;
    if (is_intt) begin
      tf = LOGN'(N_W >> s) - ONE - grp;
    end else begin
      tf = (ONE << s) + grp;
    end
  end

endmodule

// File: rtl/ntt_pair_scheduler.sv
// Walks every stage of a radix-2 NTT/INTT, issuing two butterflies per entry
// toward the pipeline FIFO, with a writeback barrier between stages.
module ntt_pair_scheduler #(
  parameter int N    = ntt_pkg::N,
  parameter int LOGN = ntt_pkg::LOGN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        start_is_intt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_is_intt,
  output logic [7:0]                  out_stage,
  output logic [7:0]                  out_counter,
  output logic [31:0]                 out_index1,
  output logic [31:0]                 out_index2,
  output logic [31:0]                 out_index3,
  output logic [31:0]                 out_index4,
  output logic [31:0]                 out_tf_index1,
  output logic [31:0]                 out_tf_index2,
  input  logic                        wb_ack,
  output logic                        busy,
  output logic                        done,
  output ntt_pkg::ntt_pipeline_data_t write_data,
  output logic                        write_en
);

  import ntt_pkg::*;

  localparam logic [LOGN-1:0] LAST_S = LOGN'(LOGN - 1);
  localparam logic [LOGN-1:0] S_STEP = LOGN'(1);
  localparam logic [LOGN-2:0] LAST_B = (LOGN - 1)'(N / 2 - 2);
  localparam logic [LOGN-2:0] B_STEP = (LOGN - 1)'(2);

  sched_state_t    state;
  logic [LOGN-1:0] s;
  logic [LOGN-2:0] b;
  logic            is_intt;

  logic [LOGN-1:0] a_lo, a_hi, a_tf;
  logic [LOGN-1:0] b_lo, b_hi, b_tf;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      s       <= '0;
      b       <= '0;
      is_intt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_intt <= start_is_intt;
            s       <= '0;
            b       <= '0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (out_ready) begin
            if (b == LAST_B) begin
              state <= S_WAIT_WB;
            end else begin
              b <= b + B_STEP;
            end
          end
        end
        // Only a pulse seen while already waiting releases the barrier.
        S_WAIT_WB: begin
          if (wb_ack) begin
            if (s == LAST_S) begin
              state <= S_DONE;
            end else begin
              s     <= s + S_STEP;
              b     <= '0;
              state <= S_ISSUE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  ntt_index_decode #(.N(N), .LOGN(LOGN)) u_dec_a (
    .s      (s),
    .bfly   (b),
    .is_intt(is_intt),
    .idx_lo (a_lo),
    .idx_hi (a_hi),
    .tf     (a_tf)
  );

  ntt_index_decode #(.N(N), .LOGN(LOGN)) u_dec_b (
    .s      (s),
    .bfly   ({b[LOGN-2:1], 1'b1}),
    .is_intt(is_intt),
    .idx_lo (b_lo),
    .idx_hi (b_hi),
    .tf     (b_tf)
  );

  assign out_valid   = (state == S_ISSUE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign write_en    = out_valid && out_ready;
  assign out_is_intt = is_intt;
  assign out_stage   = 8'(s);
  assign out_counter = 8'(b >> 1);

  // Address fields read zero outside ISSUE so the idle/reset bus is all-zero.
  assign out_index1    = out_valid ? 32'(a_lo) : '0;
  assign out_index2    = out_valid ? 32'(a_hi) : '0;
  assign out_tf_index1 = out_valid ? 32'(a_tf) : '0;
  assign out_index3    = out_valid ? 32'(b_lo) : '0;
  assign out_index4    = out_valid ? 32'(b_hi) : '0;
  assign out_tf_index2 = out_valid ? 32'(b_tf) : '0;

  always_comb begin
    write_data           = '0;
    write_data.is_intt   = out_is_intt;
    write_data.stage     = out_stage;
    write_data.counter   = out_counter;
    write_data.index1    = out_index1;
    write_data.index2    = out_index2;
    write_data.index3    = out_index3;
    write_data.index4    = out_index4;
    write_data.tf_index1 = out_tf_index1;
    write_data.tf_index2 = out_tf_index2;
  end

endmodule

// File: doc/ntt_pair_scheduler.md
Name: ntt_pair_scheduler

Overview:
- Upstream feeder of the NTT pipeline FIFO.
- On a start command, walks every stage of a radix-2 N-point forward (Cooley-Tukey) or inverse (Gentleman-Sande) NTT. Emits one entry per cycle; each entry holds two butterflies: four coefficient addresses and two twiddle-table indices.
- Uses a valid/ready handshake toward the FIFO write side.
- Enforces a stage barrier: stage s+1 is not issued until the downstream writeback acknowledges stage s.

Parameters:
- N, 256, transform length; power of two, N >= 8.
- LOGN, 8, log2(N).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_is_intt  in  1  0 = forward, 1 = inverse; sampled with start.
- out_valid  out  1  entry available.
- out_ready  in  1  FIFO can accept (driven as fifo enable && !full).
- out_is_intt  out  1  latched direction.
- out_stage  out  8  current stage index s, 0..LOGN-1.
- out_counter  out  8  entry number within stage, 0..N/4-1.
- out_index1, out_index2  out  32  butterfly A pair, zero-extended.
- out_index3, out_index4  out  32  butterfly B pair, zero-extended.
- out_tf_index1, out_tf_index2  out  32  twiddle index for butterfly A / B.
- wb_ack  in  1  one-cycle pulse: downstream finished writing back the current stage.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at transform completion.

Behaviour:
- State register: IDLE, ISSUE, WAIT_WB, DONE.
- Other registers: stage s (LOGN bits), butterfly counter b (LOGN-1 bits, even values only), is_intt.
- Reset: state=IDLE, s=0, b=0, is_intt=0. All outputs 0. Reset mid-transform abandons the operation immediately, with no done pulse.
- IDLE, start=1: latch start_is_intt, s=0, b=0, go to ISSUE. out_valid rises on the next cycle. start is ignored in every other state.
- ISSUE: out_valid=1.
  - On out_valid && out_ready with b < N/2-2: b += 2.
  - On out_valid && out_ready with b == N/2-2: go to WAIT_WB; out_valid is 0 the next cycle.
  - Without ready: all outputs held stable.
- WAIT_WB: out_valid=0.
  - On wb_ack with s == LOGN-1: go to DONE.
  - On wb_ack otherwise: s += 1, b = 0, go to ISSUE.
  - wb_ack in any other state is ignored.
  - wb_ack arriving in the same cycle as the last ISSUE handshake is ignored; the stage waits for a fresh pulse.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle that state returns to IDLE.
- Decode, combinational from registers, for butterfly b' in {b (A), b+1 (B)}:
  - Forward: len = N >> (s+1); twiddle = (1<<s) + g.
  - Inverse: len = 1 << s; twiddle = (N >> s) - 1 - g.
  - Both: g = b' / len, o = b' % len, idx_lo = 2*len*g + o, idx_hi = idx_lo + len.
  - Mapping: A gives index1/index2/tf_index1; B gives index3/index4/tf_index2.
  - When len == 1, A and B fall in different groups, so tf1 != tf2.
- out_counter = b/2; out_stage = s.
- Arithmetic uses shifts and masks only (no divider); all indices are < N.
- Entries per stage: N/4. Minimum transform latency with out_ready held high: LOGN*(N/4) issue cycles plus barrier waits.

Decomposition:
- ntt_pkg holds the shared items used by the FIFO and by this block:
  - ntt_pipeline_data_t;
  - sched_state_t enum;
  - localparams N and LOGN.
- The top level packs these outputs into the struct write_data fields and drives write_en = out_valid && out_ready.
- One natural sub-module, ntt_index_decode: combinational (s, b', is_intt) -> (idx_lo, idx_hi, tf). Instantiated twice, once for A and once for B.

Test Plan (N=8, LOGN=3):
- Forward, ready held high:
  - Entries: s0 {0,4,1,5,tf 1,1}, {2,6,3,7,tf 1,1}; s1 {0,2,1,3,tf 2,2}, {4,6,5,7,tf 3,3}; s2 {0,1,2,3,tf 4,5}, {4,5,6,7,tf 6,7}.
  - out_valid low after each pair until wb_ack; done pulses one cycle after the third wb_ack.
- Inverse: s0 entries {0,1,2,3,tf 7,6}, {4,5,6,7,tf 5,4}; s2 entry 0 = {0,4,1,5,tf 1,1}.
- Backpressure: out_ready low for 5 cycles during s0 entry 1 -> outputs unchanged throughout; entry accepted exactly once when ready rises.
- Barrier: wb_ack delayed 20 cycles -> no out_valid in that window; start pulses during busy ignored; early wb_ack in ISSUE ignored.
- Reset asserted mid-s1 -> next cycle state IDLE, busy=0, out_valid=0, no done; a new start then restarts cleanly at s0 b0.
- Back-to-back: start asserted in the cycle after done -> a new transform runs, with the direction re-latched.
